regfile_multiport: RTL and testbench
====================================

# regfile_multiport

Parametrised integer register file with configurable width, depth and read-port count, plus a per-register busy scoreboard for in-flight writebacks. Sits in the decode stage of the RISC-V core: decode reads source operands and marks destinations busy at issue; writeback writes results and clears busy. Successor to the fixed 32x64 single-write register array. Adds reset, a hardwired zero register, operand-ready flags, flush and optional write-to-read forwarding.

## Interface
- `XLEN`, default 64: data width in bits.
- `NREGS`, default 32: number of architectural registers; power of two, at least 2.
- `NRD`, default 4: number of read ports, 1..8.
- `AW`, default `$clog2(NREGS)`: address width; derived, not overridden.
- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: reset, asynchronous assert, active-low.
- `wr_en`  in  1: writeback write strobe.
- `wr_addr`  in  AW: writeback destination.
- `wr_data`  in  XLEN: writeback value.
- `rd_addr`  in  NRD x AW: read addresses, one per port.
- `rd_data`  out  NRD x XLEN: read data, one per port.
- `rd_ready`  out  NRD: operand valid (not pending) per port.
- `iss_en`  in  1: issue strobe; marks `iss_rd` busy.
- `iss_rd`  in  AW: destination of the issuing instruction.
- `flush`  in  1: clear all busy bits (pipeline squash).
- `busy_cnt`  out  `$clog2(NREGS+1)`: number of registers currently busy.

## Operation
- Storage is `NREGS` x `XLEN` flops. Register 0 always reads 0 and is never busy. Writes and issues to address 0 are ignored.
- Write: on a rising edge with `wr_en`=1 and `wr_addr`!=0, `data[wr_addr]` <= `wr_data`, and `busy[wr_addr]` is cleared.
- Issue: on a rising edge with `iss_en`=1 and `iss_rd`!=0, `busy[iss_rd]` is set.
- Write and issue to the same address in the same cycle: the data is written and busy ends up set. Issue wins because it belongs to a younger instruction.
- Flush: on a rising edge with `flush`=1, all busy bits are cleared and `iss_en` in that cycle is ignored. A write in that cycle still updates data.
- Read port p: `rd_data[p]` = `data[rd_addr[p]]`, combinational. `rd_ready[p]` = !`busy[rd_addr[p]]`.
- `busy_cnt` = population count of the busy vector, registered. It always equals the count of busy bits after the same edge.
- Reset (`rst_n`=0), asynchronous and effective at any time, including mid-issue: all data = 0, all busy = 0, `busy_cnt` = 0. Outputs during reset: `rd_data` = 0, `rd_ready` = all 1.

## Timing
- Read latency is 0 cycles (combinational from `rd_addr`).
- A write becomes visible on reads in the cycle after `wr_en`. Same-cycle visibility only with forwarding (see Configuration).
- Issue takes effect one cycle later: `rd_ready` drops in the cycle after `iss_en`.
- Busy clears in the cycle after `wr_en`, or in the same cycle when forwarding is enabled.
- `busy_cnt` updates on the same edge as the busy vector. It never exceeds `NREGS`-1.
- There is no backpressure. The caller must not issue to a register already busy; if it does, busy simply stays set.

## Configuration
- `REGFILE_BYPASS_EN` defined: per port, if `wr_en` && `wr_addr`==`rd_addr[p]` && `wr_addr`!=0, then `rd_data[p]` = `wr_data` and `rd_ready[p]` = 1 in the same cycle.
- `REGFILE_BYPASS_EN` undefined: no forwarding, and write visibility is one cycle later. Storage and scoreboard behaviour are otherwise identical.

## Structure
- Package `regfile_pkg`:
  - default constants `XLEN_D`, `NREGS_D`, `NRD_D`;
  - typedef `reg_addr_t` (logic [AW-1:0]);
  - typedef `xlen_t`;
  - function `popcount` for `busy_cnt`.
- Sub-module `regfile_read_port`, instantiated `NRD` times by generate loop. Contains the address mux, the x0 zeroing and the optional bypass compare.
- The top level holds the data array, busy vector, `busy_cnt` register and write/issue/flush logic.

## Test plan
- Reset check: assert `rst_n`=0 mid-run, then read all addresses on all 4 ports. Required: `rd_data`=0, `rd_ready`=1, `busy_cnt`=0.
- x0 protection: write `wr_addr`=0, `wr_data`=64'hDEAD_BEEF, and issue `iss_rd`=0. Required: reads of 0 return 0, `busy_cnt` stays 0.
- Scoreboard: issue r5, then r7 the next cycle. Required: `busy_cnt`=2 and `rd_ready` low on ports reading 5 and 7. Then write r5=64'h1234. Required next cycle: r5 ready, `rd_data`=64'h1234, `busy_cnt`=1.
- Collision: in one cycle, `wr_en` r9=64'hAA and `iss_en` r9. Required: r9 holds 64'hAA, busy[9]=1, `busy_cnt` incremented by 1.
- Flush: busy r3, r4 and r6, then `flush`=1 together with `iss_en` r8. Required next cycle: `busy_cnt`=0, r8 not busy.
- Bypass (with `REGFILE_BYPASS_EN` defined): r12 busy, `wr_en` r12=64'h55 with port 2 reading 12. Required same cycle: `rd_data[2]`=64'h55, `rd_ready[2]`=1. With the macro undefined: the old value is returned and ready stays 0 until the next cycle.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults, types and popcount helper for the register file
package regfile_pkg;

    localparam int XLEN_D  = 64;
    localparam int NREGS_D = 32;
    localparam int NRD_D   = 4;
    localparam int AW_D    = $clog2(NREGS_D);
    localparam int POP_W   = 256;

    typedef logic [AW_D-1:0]   reg_addr_t;
    typedef logic [XLEN_D-1:0] xlen_t;

    // Callers zero-extend their busy vector to POP_W bits.
    function automatic int unsigned popcount(input logic [POP_W-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < POP_W; i++) begin
            n = n + 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// rtl/regfile_read_port.sv - one combinational read port with x0 zeroing; forwarding under REGFILE_BYPASS_EN
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter  int XLEN  = XLEN_D,
    parameter  int NREGS = NREGS_D,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic [NREGS-1:0][XLEN-1:0] data,
    input  logic [NREGS-1:0]           busy,
    input  logic [AW-1:0]              rd_addr,
    input  logic                       fwd_en,
    input  logic [AW-1:0]              wr_addr,
    input  logic [XLEN-1:0]            wr_data,
    output logic [XLEN-1:0]            rd_data,
    output logic                       rd_ready
);

    always_comb begin
        rd_data  = data[rd_addr];
        rd_ready = !busy[rd_addr];
        if (rd_addr == '0) begin
            rd_data  = '0;
            rd_ready = 1'b1;
        end
`ifdef REGFILE_BYPASS_EN
        else if (fwd_en && (wr_addr == rd_addr)) begin
            rd_data  = wr_data;
            rd_ready = 1'b1;
        end
`endif
    end

`ifdef REGFILE_BYPASS_EN
`else
    logic unused_fwd;
    assign unused_fwd = ^{fwd_en, wr_addr, wr_data};
`endif

endmodule

// File: rtl/regfile_multiport.sv
// rtl/regfile_multiport.sv - multi-read-port register file with busy scoreboard; optional forwarding via REGFILE_BYPASS_EN
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter  int XLEN  = XLEN_D,
    parameter  int NREGS = NREGS_D,
    parameter  int NRD   = NRD_D,
    localparam int AW    = $clog2(NREGS),
    localparam int CW    = $clog2(NREGS + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic [AW-1:0]             wr_addr,
    input  logic [XLEN-1:0]           wr_data,
    input  logic [NRD-1:0][AW-1:0]    rd_addr,
    output logic [NRD-1:0][XLEN-1:0]  rd_data,
    output logic [NRD-1:0]            rd_ready,
    input  logic                      iss_en,
    input  logic [AW-1:0]             iss_rd,
    input  logic                      flush,
    output logic [CW-1:0]             busy_cnt
);

    logic [NREGS-1:0][XLEN-1:0] data_q, data_d;
    logic [NREGS-1:0]           busy_q, busy_d;
    logic [CW-1:0]              busy_cnt_q, busy_cnt_d;
    logic [POP_W-1:0]           busy_ext;
    logic                       fwd_en;

    // Issue is applied after the write so a same-cycle younger issue leaves busy set.
    always_comb begin
        data_d   = data_q;
        busy_d   = busy_q;
        busy_ext = '0;
        if (wr_en && (wr_addr != '0)) begin
            data_d[wr_addr] = wr_data;
            busy_d[wr_addr] = 1'b0;
        end
        if (flush) begin
            busy_d = '0;
        end else if (iss_en && (iss_rd != '0)) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_ext[NREGS-1:0] = busy_d;
        busy_cnt_d = CW'(popcount(busy_ext));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q     <= '0;
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            data_q     <= data_d;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy_cnt = busy_cnt_q;

    // Keeps forwarded data off the read ports while reset is held.
    assign fwd_en = wr_en & rst_n;

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        regfile_read_port #(
            .XLEN  (XLEN),
            .NREGS (NREGS)
        ) u_port (
            .data     (data_q),
            .busy     (busy_q),
            .rd_addr  (rd_addr[p]),
            .fwd_en   (fwd_en),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data),
            .rd_data  (rd_data[p]),
            .rd_ready (rd_ready[p])
        );
    end

endmodule

// File: tb/tb_regfile_multiport.sv
// tb/tb_regfile_multiport.sv - table-driven scoreboard bench for regfile_multiport
module tb_regfile_multiport;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             wr_en;
    logic [4:0]       wr_addr;
    logic [63:0]      wr_data;
    logic [3:0][4:0]  rd_addr;
    logic [3:0][63:0] rd_data;
    logic [3:0]       rd_ready;
    logic             iss_en;
    logic [4:0]       iss_rd;
    logic             flush;
    logic [5:0]       busy_cnt;

    regfile_multiport dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_ready (rd_ready),
        .iss_en   (iss_en),
        .iss_rd   (iss_rd),
        .flush    (flush),
        .busy_cnt (busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic             we;
        logic [4:0]       wa;
        logic [63:0]      wd;
        logic             ie;
        logic [4:0]       ir;
        logic             fl;
        logic [3:0][4:0]  ra;
        logic [3:0][63:0] ed;
        logic [3:0]       erdy;
        logic [5:0]       ecnt;
    } vec_t;

    typedef struct {
        string            name;
        logic [3:0][63:0] ed;
        logic [3:0]       erdy;
        logic [5:0]       ecnt;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   nvec = 0;
    int   nmis = 0;

    function automatic vec_t mk(string n, logic we, logic [4:0] wa, logic [63:0] wd,
                                logic ie, logic [4:0] ir, logic fl,
                                logic [4:0] a0, logic [4:0] a1, logic [4:0] a2, logic [4:0] a3,
                                logic [63:0] d0, logic [63:0] d1, logic [63:0] d2, logic [63:0] d3,
                                logic [3:0] rdy, logic [5:0] cnt);
        vec_t v;
        v.name = n; v.we = we; v.wa = wa; v.wd = wd;
        v.ie = ie; v.ir = ir; v.fl = fl;
        v.ra[0] = a0; v.ra[1] = a1; v.ra[2] = a2; v.ra[3] = a3;
        v.ed[0] = d0; v.ed[1] = d1; v.ed[2] = d2; v.ed[3] = d3;
        v.erdy = rdy; v.ecnt = cnt;
        return v;
    endfunction

    task automatic push_exp(input string n, input logic [3:0][63:0] ed,
                            input logic [3:0] rdy, input logic [5:0] cnt);
        exp_t e;
        e.name = n; e.ed = ed; e.erdy = rdy; e.ecnt = cnt;
        exp_q.push_back(e);
    endtask

    task automatic check();
        exp_t e;
        nvec++;
        if (exp_q.size() == 0) begin
            nmis++;
            $display("FAIL scoreboard_empty: no expected entry queued");
            return;
        end
        e = exp_q.pop_front();
        if (rd_data !== e.ed || rd_ready !== e.erdy || busy_cnt !== e.ecnt) begin
            nmis++;
            $display("FAIL %s: got data=%h ready=%b cnt=%0d, expected data=%h ready=%b cnt=%0d",
                     e.name, rd_data, rd_ready, busy_cnt, e.ed, e.erdy, e.ecnt);
        end
    endtask

    task automatic idle();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        iss_en = 1'b0; iss_rd = '0; flush = 1'b0;
    endtask

    initial begin
        logic [63:0] ones;
        logic [3:0][63:0] zd;
        ones = '1;
        zd   = '0;

        vecs.push_back(mk("reset_state", 0, 0, 0, 0, 0, 0, 0, 1, 5, 31, 0, 0, 0, 0, 4'hF, 0));
        vecs.push_back(mk("x0_write", 1, 0, 64'hDEAD_BEEF, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hF, 0));
        vecs.push_back(mk("x0_after", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hF, 0));
        vecs.push_back(mk("iss_r5", 0, 0, 0, 1, 5, 0, 5, 7, 0, 1, 0, 0, 0, 0, 4'hF, 0));
        vecs.push_back(mk("iss_r7", 0, 0, 0, 1, 7, 0, 5, 7, 0, 1, 0, 0, 0, 0, 4'b1110, 1));
        vecs.push_back(mk("busy_two", 0, 0, 0, 0, 0, 0, 5, 7, 0, 1, 0, 0, 0, 0, 4'b1100, 2));
        vecs.push_back(mk("wr_r5", 1, 5, 64'h1234, 0, 0, 0, 5, 7, 0, 1,
                          BYP ? 64'h1234 : 64'h0, 0, 0, 0, BYP ? 4'b1101 : 4'b1100, 2));
        vecs.push_back(mk("r5_done", 0, 0, 0, 0, 0, 0, 5, 7, 0, 1, 64'h1234, 0, 0, 0, 4'b1101, 1));
        vecs.push_back(mk("collide", 1, 9, 64'hAA, 1, 9, 0, 9, 5, 7, 0,
                          BYP ? 64'hAA : 64'h0, 64'h1234, 0, 0, 4'b1011, 1));
        vecs.push_back(mk("collide_after", 0, 0, 0, 0, 0, 0, 9, 5, 7, 0, 64'hAA, 64'h1234, 0, 0, 4'b1010, 2));
        vecs.push_back(mk("iss_r3", 0, 0, 0, 1, 3, 0, 3, 4, 6, 8, 0, 0, 0, 0, 4'hF, 2));
        vecs.push_back(mk("iss_r4", 0, 0, 0, 1, 4, 0, 3, 4, 6, 8, 0, 0, 0, 0, 4'b1110, 3));
        vecs.push_back(mk("iss_r6", 0, 0, 0, 1, 6, 0, 3, 4, 6, 8, 0, 0, 0, 0, 4'b1100, 4));
        vecs.push_back(mk("flush_iss_r8", 1, 3, 64'h77, 1, 8, 1, 3, 4, 6, 8,
                          BYP ? 64'h77 : 64'h0, 0, 0, 0, BYP ? 4'b1001 : 4'b1000, 5));
        vecs.push_back(mk("flush_after", 0, 0, 0, 0, 0, 0, 3, 4, 6, 8, 64'h77, 0, 0, 0, 4'hF, 0));
        vecs.push_back(mk("iss_r12", 0, 0, 0, 1, 12, 0, 0, 0, 12, 0, 0, 0, 0, 0, 4'hF, 0));
        vecs.push_back(mk("wr_r12", 1, 12, 64'h55, 0, 0, 0, 0, 0, 12, 0,
                          0, 0, BYP ? 64'h55 : 64'h0, 0, BYP ? 4'hF : 4'b1011, 1));
        vecs.push_back(mk("r12_done", 0, 0, 0, 0, 0, 0, 0, 0, 12, 0, 0, 0, 64'h55, 0, 4'hF, 0));
        vecs.push_back(mk("wr_r31", 1, 31, ones, 0, 0, 0, 31, 31, 31, 31,
                          BYP ? ones : 64'h0, BYP ? ones : 64'h0, BYP ? ones : 64'h0, BYP ? ones : 64'h0, 4'hF, 0));
        vecs.push_back(mk("r31_done", 0, 0, 0, 0, 0, 0, 31, 9, 12, 5, ones, 64'hAA, 64'h55, 64'h1234, 4'hF, 0));

        rst_n = 1'b0;
        idle();
        rd_addr = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
            iss_en = vecs[i].ie; iss_rd = vecs[i].ir; flush = vecs[i].fl;
            rd_addr = vecs[i].ra;
            push_exp(vecs[i].name, vecs[i].ed, vecs[i].erdy, vecs[i].ecnt);
            #4;
            check();
        end

        // Asynchronous reset dropped in the middle of an issue/write cycle.
        @(negedge clk);
        idle();
        iss_en = 1'b1; iss_rd = 5'd10;
        wr_en = 1'b1; wr_addr = 5'd11; wr_data = 64'hCAFE;
        rd_addr = {5'd10, 5'd9, 5'd5, 5'd31};
        #2 rst_n = 1'b0;
        push_exp("async_reset", zd, 4'hF, 6'd0);
        #1 check();
        @(posedge clk);
        #1;
        for (int a = 0; a < 32; a++) begin
            rd_addr = {4{5'(a)}};
            push_exp($sformatf("reset_read_%0d", a), zd, 4'hF, 6'd0);
            #1 check();
        end

        @(negedge clk);
        idle();
        rst_n = 1'b1;
        @(negedge clk);
        rd_addr = {5'd11, 5'd10, 5'd9, 5'd5};
        push_exp("post_reset", zd, 4'hF, 6'd0);
        #4 check();

        if (exp_q.size() != 0) begin
            nvec++;
            nmis++;
            $display("FAIL scoreboard_leftover: %0d entries remain, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
